mod_divn: RTL and testbench
===========================

MOD_DIVN -- requirements
Module: mod_divn

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width in bits (legal values 4..32).
REQ-002 The block SHALL have parameter CNT_W, default 5, giving the iteration counter width; CNT_W SHALL be at least clog2(WIDTH+1).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request to begin a division with the current X, Y and SIGNED.
REQ-006 SIGNED  input  1  0 selects unsigned division; 1 selects two's-complement division.
REQ-007 X  input  WIDTH  dividend.
REQ-008 Y  input  WIDTH  divisor.
REQ-009 Q  output  WIDTH  quotient, registered.
REQ-010 R  output  WIDTH  remainder, registered.
REQ-011 BUSY  output  1  high while iterations are in progress.
REQ-012 READY  output  1  high while Q/R/DIV0/OVF hold a valid result.
REQ-013 DIV0  output  1  the result was produced with Y == 0.
REQ-014 OVF  output  1  signed overflow, i.e. the most-negative value divided by -1.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-016 In IDLE or DONE, START high at a rising edge SHALL latch X, Y and SIGNED and clear READY, DIV0 and OVF.
- If Y != 0, the FSM SHALL go to BUSY and load the counter with WIDTH.
- If Y == 0, the FSM SHALL go directly to DONE.
REQ-017 START SHALL be ignored while in BUSY; the latched operands SHALL not change.
REQ-018 In BUSY, each edge SHALL perform one restoring shift-subtract step on the latched operand magnitudes.
- The partial remainder SHALL be WIDTH+1 bits wide, to hold the subtract borrow.
- The step SHALL produce one quotient bit, MSB first, and decrement the counter.
REQ-019 The edge on which the counter reaches zero SHALL transition the FSM to DONE and register Q and R.
- Latency SHALL be exactly WIDTH cycles from the START edge to READY high, in both modes.
REQ-020 BUSY SHALL equal 1 exactly when the state is BUSY; READY SHALL equal 1 exactly when the state is DONE.
REQ-021 The result SHALL hold in DONE until the next accepted START or reset; the FSM SHALL never return from DONE to IDLE except via reset.
REQ-022 Unsigned mode: Q = floor(X/Y), and R = X - Q*Y with 0 <= R < Y.
REQ-023 Signed mode: operands SHALL be converted to magnitudes at START.
- The quotient SHALL truncate toward zero and be negated when the operand signs differ.
- The remainder SHALL take the sign of X, with |R| < |Y|.
- Sign fixup SHALL occur on the DONE transition edge with no added latency.
REQ-024 Divide by zero: READY SHALL go high one cycle after the START edge, with the following result.
- DIV0 = 1.
- Q = all ones.
- R = X.
- OVF = 0.
REQ-025 Signed overflow (X = most-negative value, Y = all ones): the full WIDTH-cycle latency SHALL apply, with the following result.
- Q = X, i.e. the wrapped value.
- R = 0.
- OVF = 1.
REQ-026 When X < Y (unsigned) or |X| < |Y| (signed), the block SHALL give Q = 0 and R = X.
REQ-027 Q and R SHALL change only on the DONE transition edge or on reset; they SHALL not show intermediate values.

Reset
REQ-028 RESET_N low SHALL immediately, without waiting for a clock edge, force the following state.
- FSM = IDLE and counter = 0.
- Q = 0, R = 0.
- BUSY = 0, READY = 0, DIV0 = 0, OVF = 0.
REQ-029 A reset asserted during BUSY SHALL abort the division; no result SHALL appear after deassertion.
REQ-030 After RESET_N rises, the first edge with START high SHALL be accepted normally.

Verification (WIDTH=16)
REQ-031 Unsigned: X=100, Y=7, START for 1 cycle -> BUSY for 16 cycles, then READY=1, Q=14, R=2, DIV0=0, OVF=0.
REQ-032 Divide by zero: X=1234, Y=0 -> READY one cycle after START, DIV0=1, Q=16'hFFFF, R=16'h04D2.
REQ-033 Signed: X=-7 (16'hFFF9), Y=2 -> Q=16'hFFFD (-3), R=16'hFFFF (-1); and X=7, Y=-2 -> Q=16'hFFFD, R=1.
REQ-034 Signed overflow: X=16'h8000, Y=16'hFFFF -> Q=16'h8000, R=0, OVF=1, READY after 16 cycles.
REQ-035 START with X=50, Y=3, then START with X=9, Y=9 at cycle 5 -> second START ignored, result Q=16, R=2; a following START from DONE with X=5, Y=9 -> READY drops, then Q=0, R=5.
REQ-036 RESET_N pulsed low at cycle 8 of a division -> all outputs 0 asynchronously, IDLE after release, no READY until a new START.

Source files
------------

// File: rtl/mod_divn.sv
// Iterative restoring divider, unsigned or two's-complement, one quotient bit per clock.
// Latency: WIDTH cycles from the accepted START edge to READY; divide-by-zero is ready at the START edge.
// Backpressure: none; START is ignored while BUSY, and the result holds in DONE until the next START.
//
// Ports:
//   CLK, RESET_N     clock, asynchronous active-low reset
//   START, SIGNED    begin a division of X by Y; SIGNED selects two's-complement mode
//   X, Y             dividend, divisor (WIDTH bits)
//   Q, R             registered quotient and remainder
//   BUSY, READY      iterating / result valid
//   DIV0, OVF        result was a divide-by-zero / signed overflow (most-negative / -1)
module mod_divn #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             BUSY,
   output logic             READY,
   output logic             DIV0,
   output logic             OVF
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   prem;      // partial remainder, one extra bit for the borrow
   logic [WIDTH-1:0] quo;       // dividend bits shift out at the top, quotient bits shift in below
   logic [WIDTH-1:0] dvsr;      // divisor magnitude
   logic             neg_q;     // operand signs differ in signed mode
   logic             neg_r;     // remainder follows the sign of the dividend
   logic             ovf_l;

   logic [WIDTH-1:0] x_mag;
   logic [WIDTH-1:0] y_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             qbit;
   logic [WIDTH:0]   prem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             ovf_in;

   always_comb begin
      x_mag   = (SIGNED && X[WIDTH-1]) ? (~X + 1'b1) : X;
      y_mag   = (SIGNED && Y[WIDTH-1]) ? (~Y + 1'b1) : Y;
      ovf_in  = SIGNED && (X == MOST_NEG) && (Y == {WIDTH{1'b1}});

      // One restoring step: bring down the next dividend bit, try the subtract,
      // keep it only if it did not borrow.
      shifted = {prem[WIDTH-1:0], quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvsr};
      qbit    = ~diff[WIDTH];
      prem_nx = qbit ? diff : shifted;
      quo_nx  = {quo[WIDTH-2:0], qbit};

      // Sign fixup is folded into the final step so it costs no extra cycle.
      q_fix   = neg_q ? (~quo_nx + 1'b1) : quo_nx;
      r_fix   = neg_r ? (~prem_nx[WIDTH-1:0] + 1'b1) : prem_nx[WIDTH-1:0];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= ST_IDLE;
         cnt   <= '0;
         prem  <= '0;
         quo   <= '0;
         dvsr  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         ovf_l <= 1'b0;
         Q     <= '0;
         R     <= '0;
         BUSY  <= 1'b0;
         READY <= 1'b0;
         DIV0  <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  DIV0  <= 1'b0;
                  OVF   <= 1'b0;
                  neg_q <= SIGNED & (X[WIDTH-1] ^ Y[WIDTH-1]);
                  neg_r <= SIGNED & X[WIDTH-1];
                  ovf_l <= ovf_in;
                  if (Y == '0) begin
                     state <= ST_DONE;
                     BUSY  <= 1'b0;
                     READY <= 1'b1;
                     DIV0  <= 1'b1;
                     Q     <= '1;
                     R     <= X;
                  end else begin
                     state <= ST_BUSY;
                     BUSY  <= 1'b1;
                     READY <= 1'b0;
                     cnt   <= CNT_W'(WIDTH);
                     prem  <= '0;
                     quo   <= x_mag;
                     dvsr  <= y_mag;
                  end
               end
            end
            ST_BUSY: begin
               prem <= prem_nx;
               quo  <= quo_nx;
               cnt  <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= ST_DONE;
                  BUSY  <= 1'b0;
                  READY <= 1'b1;
                  Q     <= q_fix;
                  R     <= r_fix;
                  OVF   <= ovf_l;
               end
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
               READY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_divn.sv
// Directed bench for mod_divn (WIDTH=16) with a scoreboard queue and an independent monitor.
// The monitor pops one expected result on each READY rising edge, including its ready cycle.
// Stimulus pushes hand-computed results; aborted or ignored STARTs push nothing.
module tb_mod_divn;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b1;
   logic        START = 1'b0;
   logic        SIGNED = 1'b0;
   logic [15:0] X = '0;
   logic [15:0] Y = '0;
   logic [15:0] Q;
   logic [15:0] R;
   logic        BUSY;
   logic        READY;
   logic        DIV0;
   logic        OVF;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        d0;
      logic        ovf;
      int          rdy_cyc;
   } exp_t;

   exp_t sb[$];

   mod_divn #(.WIDTH(16), .CNT_W(5)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .SIGNED(SIGNED),
      .X(X), .Y(Y), .Q(Q), .R(R),
      .BUSY(BUSY), .READY(READY), .DIV0(DIV0), .OVF(OVF)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every new result against the head of the scoreboard.
   logic ready_q = 1'b0;
   always @(negedge CLK) begin
      exp_t e;
      if (READY && !ready_q) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: READY rose at cycle %0d with nothing expected", cyc);
         end else begin
            e = sb.pop_front();
            chk("q", 32'(Q), 32'(e.q));
            chk("r", 32'(R), 32'(e.r));
            chk("div0", 32'(DIV0), 32'(e.d0));
            chk("ovf", 32'(OVF), 32'(e.ovf));
            chk("ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
         end
      end
      ready_q = READY;
   end

   // Called just after a falling edge; the next rising edge accepts the request.
   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic sg,
                        input logic push, input logic [15:0] eq, input logic [15:0] er,
                        input logic ed, input logic eo);
      exp_t e;
      if (push) begin
         e.q = eq; e.r = er; e.d0 = ed; e.ovf = eo;
         e.rdy_cyc = cyc + 1 + ((y == 16'd0) ? 0 : 16);
         sb.push_back(e);
      end
      START = 1'b1; X = x; Y = y; SIGNED = sg;
      @(negedge CLK);
      START = 1'b0;
      if (y != 16'd0) begin
         chk("busy_after_start", 32'(BUSY), 32'd1);
         chk("ready_cleared", 32'(READY), 32'd0);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60; i++) begin
         if (sb.size() == 0) break;
         @(negedge CLK);
      end
      @(negedge CLK);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_q"}, 32'(Q), 32'd0);
      chk({tag, "_r"}, 32'(R), 32'd0);
      chk({tag, "_busy"}, 32'(BUSY), 32'd0);
      chk({tag, "_ready"}, 32'(READY), 32'd0);
      chk({tag, "_div0"}, 32'(DIV0), 32'd0);
      chk({tag, "_ovf"}, 32'(OVF), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_N = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   initial begin
      #2 RESET_N = 1'b0;
      #1 check_all_zero("reset");
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Divide by zero straight out of IDLE.
      issue(16'd1234, 16'd0, 1'b0, 1'b1, 16'hFFFF, 16'h04D2, 1'b1, 1'b0);
      wait_done();

      // Unsigned and signed directed cases.
      issue(16'd100,  16'd7,     1'b0, 1'b1, 16'd14,   16'd2,    1'b0, 1'b0);
      wait_done();
      issue(16'hFFF9, 16'd2,     1'b1, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
      wait_done();
      issue(16'd7,    16'hFFFE,  1'b1, 1'b1, 16'hFFFD, 16'd1,    1'b0, 1'b0);
      wait_done();
      issue(16'hFFF8, 16'hFFFD,  1'b1, 1'b1, 16'd2,    16'hFFFE, 1'b0, 1'b0);
      wait_done();
      issue(16'h8000, 16'hFFFF,  1'b1, 1'b1, 16'h8000, 16'd0,    1'b0, 1'b1);
      wait_done();
      issue(16'hFFFF, 16'd1,     1'b0, 1'b1, 16'hFFFF, 16'd0,    1'b0, 1'b0);
      wait_done();
      issue(16'd3,    16'd10,    1'b0, 1'b1, 16'd0,    16'd3,    1'b0, 1'b0);
      wait_done();
      issue(16'hFFFD, 16'd7,     1'b1, 1'b1, 16'd0,    16'hFFFD, 1'b0, 1'b0);
      wait_done();
      // Unsigned mode must not treat a set MSB as a sign.
      issue(16'h8000, 16'hFFFF,  1'b0, 1'b1, 16'd0,    16'h8000, 1'b0, 1'b0);
      wait_done();

      // A START during BUSY is ignored and does not disturb the operands.
      issue(16'd50, 16'd3, 1'b0, 1'b1, 16'd16, 16'd2, 1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      START = 1'b1; X = 16'd9; Y = 16'd9; SIGNED = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      chk("busy_after_ignored_start", 32'(BUSY), 32'd1);
      wait_done();
      issue(16'd5, 16'd9, 1'b0, 1'b1, 16'd0, 16'd5, 1'b0, 1'b0);
      wait_done();

      // Signed divide by zero keeps the raw dividend as remainder.
      do_reset();
      issue(16'hFFFB, 16'd0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0);
      wait_done();

      // Reset in the middle of a division aborts it with no late result.
      issue(16'd1000, 16'd3, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (6) @(negedge CLK);
      #2 RESET_N = 1'b0;
      #1 check_all_zero("async_abort");
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (25) @(negedge CLK);
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_ready", 32'(READY), 32'd0);

      // First START after reset is accepted normally.
      issue(16'd20, 16'd6, 1'b0, 1'b1, 16'd3, 16'd2, 1'b0, 1'b0);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
